mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester memory port arbiter: an instruction-fetch port and a data-access port share one
// memory controller CPU port. The data port has priority unless the fetch port has waited too long.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        Clk,
    input  logic        Rst,

    input  logic        IF_En,
    input  logic [31:0] IF_Address,
    output logic        IF_Stall,
    output logic [31:0] IF_OData,

    input  logic        MA_En,
    input  logic        MA_RW,
    input  logic [31:0] MA_Address,
    input  logic [31:0] MA_IData,
    output logic        MA_Stall,
    output logic [31:0] MA_OData,

    output logic        M_En,
    output logic        M_RW,
    output logic [31:0] M_Address,
    output logic [31:0] M_IData,
    input  logic        M_Stall,
    input  logic [31:0] M_OData,

    output logic [1:0]  Grant
);

    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 32;
    localparam int unsigned WaitWidth = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GNT_IF = 2'b01,
        GNT_MA = 2'b10
    } arbState_t;

    typedef struct packed {
        logic                 rw;
        logic [AddrWidth-1:0] address;
        logic [DataWidth-1:0] wrData;
    } memReq_t;

    arbState_t            state;
    memReq_t              latched;
    logic [WaitWidth-1:0] waitCnt;
    logic [DataWidth-1:0] ifODataReg;
    logic [DataWidth-1:0] maODataReg;

    logic starved;
    logic ifWins;
    logic ifDone;
    logic maDone;

    // Arbitration decision and per-port completion strobes
    always_comb begin
        starved = IF_En && (32'(waitCnt) >= STARVE_LIMIT);
        ifWins  = IF_En && (!MA_En || starved);
        ifDone  = (state == GNT_IF) && !M_Stall;
        maDone  = (state == GNT_MA) && !M_Stall;
    end

    // Grant FSM, request latches, fetch wait counter and read-data holding registers
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state      <= IDLE;
            latched    <= '0;
            waitCnt    <= '0;
            ifODataReg <= '0;
            maODataReg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ifWins) begin
                        state          <= GNT_IF;
                        latched.rw     <= 1'b0;
                        latched.address <= IF_Address;
                        latched.wrData <= '0;
                    end else if (MA_En) begin
                        state          <= GNT_MA;
                        latched.rw     <= MA_RW;
                        latched.address <= MA_Address;
                        latched.wrData <= MA_IData;
                    end
                end
                GNT_IF, GNT_MA: begin
                    // Grant is held with latched fields even if the requester abandons
                    if (!M_Stall) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (!IF_En) begin
                waitCnt <= '0;
            end else if ((state == IDLE) && ifWins) begin
                waitCnt <= '0;
            end else if ((state != GNT_IF) && (waitCnt != '1)) begin
                waitCnt <= waitCnt + WaitWidth'(1);
            end

            if (ifDone) begin
                ifODataReg <= M_OData;
            end
            if (maDone) begin
                maODataReg <= M_OData;
            end
        end
    end

    // Memory-side drive: latched request while granted, all zero when idle
    always_comb begin
        Grant     = state;
        M_En      = (state != IDLE);
        M_RW      = M_En && latched.rw;
        M_Address = M_En ? latched.address : '0;
        M_IData   = M_En ? latched.wrData : '0;
    end

    // Requester-side status: read data passes straight through in the completion cycle
    always_comb begin
        IF_Stall = IF_En && !ifDone;
        MA_Stall = MA_En && !maDone;
        IF_OData = ifDone ? M_OData : ifODataReg;
        MA_OData = maDone ? M_OData : maODataReg;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic, with a transaction-level
// reference model feeding an expected-transaction queue drained by an independent monitor.
module tb_mem_port_arbiter;

    localparam int unsigned StarveLimit = 4;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        IF_En;
    logic [31:0] IF_Address;
    logic        IF_Stall;
    logic [31:0] IF_OData;
    logic        MA_En;
    logic        MA_RW;
    logic [31:0] MA_Address;
    logic [31:0] MA_IData;
    logic        MA_Stall;
    logic [31:0] MA_OData;
    logic        M_En;
    logic        M_RW;
    logic [31:0] M_Address;
    logic [31:0] M_IData;
    logic        M_Stall;
    logic [31:0] M_OData;
    logic [1:0]  Grant;

    typedef struct packed {
        logic [1:0]  gnt;
        logic        rw;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    int          nChecks = 0;
    int          nErrors = 0;
    txn_t        expQ[$];
    logic [1:0]  modelGrant = 2'b00;
    logic [1:0]  nextGrant;
    int          ifWait = 0;
    logic [31:0] expIfOData = '0;
    logic [31:0] expMaOData = '0;
    txn_t        head;
    logic [1:0]  starveExp [11];

    mem_port_arbiter #(.STARVE_LIMIT(StarveLimit)) dut (
        .Clk(Clk), .Rst(Rst),
        .IF_En(IF_En), .IF_Address(IF_Address), .IF_Stall(IF_Stall), .IF_OData(IF_OData),
        .MA_En(MA_En), .MA_RW(MA_RW), .MA_Address(MA_Address), .MA_IData(MA_IData),
        .MA_Stall(MA_Stall), .MA_OData(MA_OData),
        .M_En(M_En), .M_RW(M_RW), .M_Address(M_Address), .M_IData(M_IData),
        .M_Stall(M_Stall), .M_OData(M_OData),
        .Grant(Grant)
    );

    always #5 Clk = ~Clk;

    // Memory contents: a fixed function of address, 0x100 reads 0xDEADBEEF
    function automatic logic [31:0] readData(input logic [31:0] a);
        return 32'hDEADBEEF ^ a ^ 32'h0000_0100;
    endfunction

    assign M_OData = readData(M_Address);

    function automatic txn_t mkTxn(input logic [1:0] g, input logic rw,
                                   input logic [31:0] a, input logic [31:0] d);
        txn_t t;
        t.gnt  = g;
        t.rw   = rw;
        t.addr = a;
        t.data = d;
        return t;
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Reference model: who gets the port next, and what must be presented to memory
    always @(posedge Clk) begin
        if (Rst) begin
            modelGrant = 2'b00;
            ifWait     = 0;
            expQ.delete();
            expIfOData = '0;
            expMaOData = '0;
        end else begin
            nextGrant = modelGrant;
            if (modelGrant == 2'b00) begin
                if (IF_En && (!MA_En || ifWait >= int'(StarveLimit))) begin
                    nextGrant = 2'b01;
                    expQ.push_back(mkTxn(2'b01, 1'b0, IF_Address, 32'h0));
                end else if (MA_En) begin
                    nextGrant = 2'b10;
                    expQ.push_back(mkTxn(2'b10, MA_RW, MA_Address, MA_IData));
                end
            end else if (!M_Stall) begin
                nextGrant = 2'b00;
            end
            if (!IF_En) ifWait = 0;
            else if (modelGrant == 2'b00 && nextGrant == 2'b01) ifWait = 0;
            else if (modelGrant != 2'b01) ifWait = (ifWait < 15) ? ifWait + 1 : 15;
            modelGrant = nextGrant;
        end
    end

    // Monitor: compare every presented output against the model on the falling edge
    always @(negedge Clk) begin
        if (!Rst) begin
            check("grant", 96'(Grant), 96'(modelGrant));
            check("if_stall", 96'(IF_Stall), 96'(IF_En && !(modelGrant == 2'b01 && !M_Stall)));
            check("ma_stall", 96'(MA_Stall), 96'(MA_En && !(modelGrant == 2'b10 && !M_Stall)));
            if (modelGrant == 2'b00) begin
                check("m_bus_idle", 96'({M_En, M_RW, M_Address, M_IData}), 96'(0));
            end else if (expQ.size() == 0) begin
                nChecks++;
                nErrors++;
                $display("FAIL scoreboard: grant %0d active with no expected transaction", modelGrant);
            end else begin
                head = expQ[0];
                check("m_bus_gnt", 96'({M_En, M_RW, M_Address, M_IData}),
                      96'({1'b1, head.rw, head.addr, head.data}));
                if (!M_Stall) begin
                    void'(expQ.pop_front());
                    if (head.gnt == 2'b01) expIfOData = readData(head.addr);
                    else                   expMaOData = readData(head.addr);
                end
            end
            check("if_odata", 96'(IF_OData), 96'(expIfOData));
            check("ma_odata", 96'(MA_OData), 96'(expMaOData));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int phase;
        starveExp = '{2'd2, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd1};
        IF_En = 1'b0; IF_Address = '0;
        MA_En = 1'b0; MA_RW = 1'b0; MA_Address = '0; MA_IData = '0;
        M_Stall = 1'b0;

        step();
        check("rst_grant", 96'(Grant), 96'(0));
        check("rst_mbus", 96'({M_En, M_RW, M_Address, M_IData}), 96'(0));
        check("rst_if_odata", 96'(IF_OData), 96'(0));
        check("rst_ma_odata", 96'(MA_OData), 96'(0));
        step();
        Rst = 1'b0;

        // Single data read at 0x100
        MA_En = 1'b1; MA_RW = 1'b0; MA_Address = 32'h100; M_Stall = 1'b0;
        step();
        check("rd_mbus", 96'({M_En, M_Address, MA_Stall}), 96'({1'b1, 32'h100, 1'b0}));
        check("rd_odata_c1", 96'(MA_OData), 96'(32'hDEADBEEF));
        step();
        MA_En = 1'b0;
        check("rd_odata_c2", 96'(MA_OData), 96'(32'hDEADBEEF));
        step();

        // Simultaneous fetch and data write: data first, fetch after one idle cycle
        IF_En = 1'b1; IF_Address = 32'h40;
        MA_En = 1'b1; MA_RW = 1'b1; MA_Address = 32'h200; MA_IData = 32'h55;
        step();
        check("sim_ma_first", 96'({Grant, M_RW, M_IData}), 96'({2'b10, 1'b1, 32'h55}));
        step();
        MA_En = 1'b0;
        check("sim_bubble", 96'(Grant), 96'(0));
        step();
        check("sim_if_next", 96'({Grant, M_RW, M_Address}), 96'({2'b01, 1'b0, 32'h40}));
        step();
        IF_En = 1'b0;
        step();
        step();

        // Starvation: both requesting continuously with no memory stall
        IF_En = 1'b1; IF_Address = 32'h80;
        MA_En = 1'b1; MA_RW = 1'b0; MA_Address = 32'h300;
        for (int i = 0; i < 11; i++) begin
            step();
            check($sformatf("starve_gnt%0d", i + 1), 96'(Grant), 96'(starveExp[i]));
        end
        IF_En = 1'b0; MA_En = 1'b0;
        step();
        step();

        // Fetch held by a five-cycle memory stall
        IF_En = 1'b1; IF_Address = 32'h440; M_Stall = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("hold_c%0d", i + 1), 96'({M_En, M_Address, IF_Stall}),
                  96'({1'b1, 32'h440, 1'b1}));
            step();
        end
        M_Stall = 1'b0;
        #1;
        check("hold_release", 96'({IF_Stall, IF_OData}), 96'({1'b0, readData(32'h440)}));
        step();
        IF_En = 1'b0;
        step();

        // Data requester abandons during a stalled grant
        MA_En = 1'b1; MA_RW = 1'b1; MA_Address = 32'h500; MA_IData = 32'h77; M_Stall = 1'b1;
        step();
        MA_En = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("abandon_c%0d", i + 1), 96'({Grant, MA_Stall, M_Address}),
                  96'({2'b10, 1'b0, 32'h500}));
            step();
        end
        M_Stall = 1'b0;
        #1;
        check("abandon_done", 96'({Grant, MA_Stall, MA_OData}), 96'({2'b10, 1'b0, readData(32'h500)}));
        step();
        check("abandon_idle", 96'({Grant, MA_OData}), 96'({2'b00, readData(32'h500)}));

        // Reset asserted between edges in the middle of a data grant
        MA_En = 1'b1; MA_RW = 1'b0; MA_Address = 32'h600; M_Stall = 1'b1;
        step();
        #2;
        Rst = 1'b1;
        #1;
        check("midrst_bus", 96'({Grant, M_En, M_RW, M_Address, M_IData}), 96'(0));
        check("midrst_odata", 96'({IF_OData, MA_OData}), 96'(0));
        @(posedge Clk);
        #1;
        Rst = 1'b0; MA_En = 1'b0; M_Stall = 1'b0;
        step();

        // Random traffic in phases: normal, contention without stalls, heavy stalls
        for (int i = 0; i < 3000; i++) begin
            phase = (i / 200) % 3;
            if (phase == 1) begin
                IF_En = ($urandom_range(9) < 9);
                MA_En = ($urandom_range(9) < 9);
                M_Stall = 1'b0;
            end else begin
                if ($urandom_range(3) == 0) IF_En = ($urandom_range(9) < 6);
                if ($urandom_range(3) == 0) MA_En = ($urandom_range(9) < 6);
                M_Stall = (phase == 2) ? ($urandom_range(9) < 7) : ($urandom_range(9) < 3);
            end
            if ($urandom_range(3) == 0) IF_Address = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(3) == 0) begin
                MA_Address = $urandom & 32'hFFFF_FFFC;
                MA_RW      = 1'($urandom_range(1));
                MA_IData   = $urandom;
            end
            step();
        end

        IF_En = 1'b0; MA_En = 1'b0; M_Stall = 1'b0;
        step();
        step();
        step();
        check("drain", 96'(expQ.size()), 96'(0));

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
